// File: rtl/count_monitor.sv
// count_monitor
//   Health checker for the free-running up counter. It samples the count bus
//   every rising edge, locks after a run of correct increments, and then
//   flags any skip or stall as a fault. A jump to zero while locked is taken
//   as a legitimate counter restart rather than a fault. Wraps from the
//   maximum value back to zero are counted while locked.
//
// Ports
//   clk           : clock, all state updates on the rising edge
//   reset         : asynchronous active-high reset, clears all state
//   count_in      : count bus under observation (WIDTH bits)
//   clear         : synchronous clear of err_count, wrap_count, error_sticky
//   locked        : high while the monitor is locked to the sequence
//   expected      : value required on the next edge while locked, else 0
//   error_pulse   : one-cycle strobe per detected fault
//   error_sticky  : set on any fault, cleared by reset or clear
//   restart_pulse : one-cycle strobe when a locked sequence restarts at 0
//   err_count     : saturating fault counter (CNT_W bits)
//   wrap_count    : saturating count of max->0 wraps seen while locked
//   state         : FSM state for observation (0 UNSYNC, 1 SYNC, 2 LOCKED)
//
// Handshake: none. count_in is treated as valid on every rising edge and
// the monitor is always ready; there is no back-pressure.

module count_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             error_pulse,
  output logic             error_sticky,
  output logic             restart_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic [1:0]       state
);

  // run must be able to hold 0..LOCK_LEN
  localparam int RUN_W = (LOCK_LEN < 2) ? 1 : $clog2(LOCK_LEN + 1);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           st;
  state_t           st_next;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] prev_succ;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_next;
  logic             inc;
  logic             fault;
  logic             restart;
  logic             wrap;

  assign state     = st;
  assign prev_succ = prev + WIDTH'(1);
  assign inc       = (count_in == prev_succ);

  always_comb begin
    st_next  = st;
    run_next = run;
    fault    = 1'b0;
    restart  = 1'b0;
    wrap     = 1'b0;
    case (st)
      UNSYNC: begin
        // capture only; there is no reference value yet
        st_next  = SYNC;
        run_next = '0;
      end
      SYNC: begin
        if (inc) begin
          if (int'(run) + 1 == LOCK_LEN) begin
            st_next  = LOCKED;
            run_next = '0;
          end else begin
            run_next = run + RUN_W'(1);
          end
        end else begin
          run_next = '0;
        end
      end
      LOCKED: begin
        if (inc) begin
          wrap = (prev == '1);
        end else begin
          st_next  = SYNC;
          run_next = '0;
          // a jump to zero is the counter being restarted, not a fault
          if (count_in == '0) restart = 1'b1;
          else                fault   = 1'b1;
        end
      end
      default: begin
        st_next  = UNSYNC;
        run_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st            <= UNSYNC;
      prev          <= '0;
      run           <= '0;
      locked        <= 1'b0;
      expected      <= '0;
      error_pulse   <= 1'b0;
      error_sticky  <= 1'b0;
      restart_pulse <= 1'b0;
      err_count     <= '0;
      wrap_count    <= '0;
    end else begin
      st            <= st_next;
      prev          <= count_in;
      run           <= run_next;
      locked        <= (st_next == LOCKED);
      expected      <= (st_next == LOCKED) ? count_in + WIDTH'(1) : '0;
      error_pulse   <= fault;
      restart_pulse <= restart;

      // a fault on the same edge as clear still registers
      if (fault)      error_sticky <= 1'b1;
      else if (clear) error_sticky <= 1'b0;

      if (clear)                          err_count <= fault ? CNT_W'(1) : '0;
      else if (fault && err_count != '1)  err_count <= err_count + CNT_W'(1);

      if (clear)                          wrap_count <= wrap ? CNT_W'(1) : '0;
      else if (wrap && wrap_count != '1)  wrap_count <= wrap_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/count_monitor.md
# count_monitor

Checker that sits on the 4-bit count bus driven by the free-running up counter and consumes it. Each clock it compares the sampled count against the expected successor, locks onto a valid increment sequence, and reports skips and stalls as errors. It also counts wrap-arounds and distinguishes a legitimate counter restart to zero from a fault. Used in-system as a health monitor and in benches as a self-checking consumer of the counter.

## Interface
- WIDTH, 4, width of the monitored count bus
- LOCK_LEN, 2, consecutive correct increments required to declare lock (≥1)
- CNT_W, 8, width of the err_count and wrap_count statistics counters
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- count_in  input  WIDTH  count bus from the counter, sampled every rising edge
- clear  input  1  synchronous clear of err_count, wrap_count and error_sticky
- locked  output  1  high while in LOCKED
- expected  output  WIDTH  value required on the next edge (prev+1 mod 2^WIDTH) while locked; 0 otherwise
- error_pulse  output  1  one-cycle strobe per detected fault
- error_sticky  output  1  set on any fault; cleared only by reset or clear
- restart_pulse  output  1  one-cycle strobe when a locked sequence restarts at 0
- err_count  output  CNT_W  faults since reset/clear, saturating at all-ones
- wrap_count  output  CNT_W  max→0 wraps observed while locked, saturating

## Operation
- Internal state: prev (WIDTH), run (0..LOCK_LEN), FSM state UNSYNC / SYNC / LOCKED.
- inc = (count_in == prev + 1 mod 2^WIDTH).
- UNSYNC (reset state): on the next edge, prev <= count_in, run <= 0, go to SYNC. No checks.
- SYNC: each edge, prev <= count_in. If inc: run <= run+1; when run+1 == LOCK_LEN, go to LOCKED and clear run. If not inc: run <= 0 and stay in SYNC. SYNC never reports errors.
- LOCKED: each edge, prev <= count_in.
  - inc and prev == 2^WIDTH-1 (so count_in == 0): wrap_count += 1 (saturating). Stay in LOCKED.
  - inc otherwise: stay in LOCKED.
  - not inc and count_in == 0: restart. restart_pulse = 1, go to SYNC with run = 0, no error.
  - not inc and count_in != 0 (skip or stall, including a repeated value): error_pulse = 1, error_sticky <= 1, err_count += 1 (saturating), go to SYNC with run = 0.
- clear: zeroes err_count, wrap_count and error_sticky. It does not affect FSM state, prev, run or locked.
- Clear coinciding with a fault: the fault wins. err_count = 1 and error_sticky = 1 after that edge.
- Clear coinciding with a wrap: wrap_count = 1.
- Saturation: counters hold at 2^CNT_W-1. They never wrap.

## Timing
- All outputs are registered. Nothing is combinational from count_in to any output.
- Latency: the response to a value sampled at edge N is visible after edge N; strobes are high for exactly the cycle between edges N and N+1.
- Lock latency from reset deassertion with a clean incrementing stream: LOCK_LEN+1 edges (1 capture edge plus LOCK_LEN increments).
- First fault check: the edge after locked rises.
- Reset values: locked = 0, expected = 0, error_pulse = 0, error_sticky = 0, restart_pulse = 0, err_count = 0, wrap_count = 0, state = UNSYNC, prev = 0, run = 0.
- Reset asserted mid-operation: all of the above take effect immediately, without waiting for a clock edge. After release, behaviour is as from power-up.
- error_pulse and restart_pulse are mutually exclusive. Back-to-back faults cannot occur, because a fault drops the block to SYNC.

## Test plan
(WIDTH=4, LOCK_LEN=2, CNT_W=8 unless stated.)
- Reset: hold reset with random count_in → all outputs 0. Release and drive 0,1,2 → locked = 1 after the third edge, expected = 3.
- Free run: drive 0..15,0,1 continuously → no error_pulse. wrap_count = 1 after the 15→0 edge. locked stays 1 throughout.
- Skip: after lock, drive …4,5,7 → error_pulse for one cycle, err_count = 1, error_sticky = 1, locked = 0. Then drive 8,9 → locked = 1 again; error_sticky stays 1.
- Stall and restart: after lock, drive 6,6 → fault, err_count increments. Separately, after lock drive 9,0,0,1,2 → restart_pulse once, no error, locked returns after the 2.
- Clear and saturation: with CNT_W=2, force 5 faults → err_count = 3. Assert clear on the same edge as a fault → err_count = 1 and error_sticky = 1. Assert clear alone → both read 0.
- Asynchronous reset mid-lock: pulse reset between edges → all outputs 0 before the next edge. Relock occurs 3 edges after release.
